// File: rtl/steering_slew_ctrl_if.sv
// steering_slew_ctrl_if
// ---------------------
// Bundles the command side and the Arduino link side of the steering slew
// controller so the controller and its driver can be hooked up as one port.
//
// Signals (WIDTH = bit width of every direction value):
//   targetDirection      requested steering direction, unsigned
//   target_valid         one-cycle strobe that captures targetDirection
//   reset_Pos            one-cycle strobe that requests homing
//   ard_ready            Arduino link accepts the current word
//   targetDirection_Ard  commanded direction sent to the Arduino
//   reset_Pos_Ard        high while homing
//   ard_valid            targetDirection_Ard holds an untransferred word
//   at_target            commanded direction equals goal and controller idle
//   busy                 controller is slewing or homing
//
// Modports:
//   master  the commanding side (drives the strobes and ard_ready)
//   slave   the controller itself
interface steering_slew_ctrl_if #(
  parameter int WIDTH = 9
);
  logic [WIDTH-1:0] targetDirection;
  logic             target_valid;
  logic             reset_Pos;
  logic             ard_ready;
  logic [WIDTH-1:0] targetDirection_Ard;
  logic             reset_Pos_Ard;
  logic             ard_valid;
  logic             at_target;
  logic             busy;

  modport master (
    output targetDirection,
    output target_valid,
    output reset_Pos,
    output ard_ready,
    input  targetDirection_Ard,
    input  reset_Pos_Ard,
    input  ard_valid,
    input  at_target,
    input  busy
  );

  modport slave (
    input  targetDirection,
    input  target_valid,
    input  reset_Pos,
    input  ard_ready,
    output targetDirection_Ard,
    output reset_Pos_Ard,
    output ard_valid,
    output at_target,
    output busy
  );
endinterface

// File: rtl/steering_slew_ctrl.sv
// steering_slew_ctrl
// ------------------
// Rate-limits steering commands toward an Arduino. A requested direction is
// latched as the goal, and the commanded direction (current) walks toward it
// by at most STEP per update tick. A homing request walks current back to
// HOME_POS. The Arduino link is a valid/ready pair; while the link holds off
// an untransferred word, current is frozen and the tick is dropped.
//
// Parameters:
//   WIDTH     bit width of all direction values
//   STEP      maximum change of current per update tick
//   DIV       CLOCK_50 cycles per update tick (DIV >= 1)
//   HOME_POS  direction driven during homing
//   MIN_POS   lower clamp bound (only with STEERING_CLAMP_EN)
//   MAX_POS   upper clamp bound (only with STEERING_CLAMP_EN)
//
// Ports:
//   CLOCK_50  sole clock, all logic on its rising edge
//   reset     synchronous active-high reset
//   bus       steering_slew_ctrl_if.slave (command strobes, Arduino link,
//             status outputs)
//
// Build option:
//   STEERING_CLAMP_EN  when defined, targetDirection is clamped to
//                      [MIN_POS, MAX_POS] before it is loaded into goal.
module steering_slew_ctrl #(
  parameter int WIDTH    = 9,
  parameter int STEP     = 4,
  parameter int DIV      = 2,
  parameter int HOME_POS = 0,
  parameter int MIN_POS  = 0,
  parameter int MAX_POS  = 511
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  steering_slew_ctrl_if.slave  bus
);

  localparam int                CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [WIDTH-1:0]  HOME_VAL = WIDTH'(HOME_POS);
  localparam logic [WIDTH:0]    STEP_VAL = (WIDTH + 1)'(STEP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLEW = 2'd1,
    HOME = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] goal;
  logic [WIDTH-1:0] goal_n;
  logic [WIDTH-1:0] current;
  logic [WIDTH-1:0] current_n;
  logic             ard_valid_q;
  logic             ard_valid_n;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic             stall;
  logic [WIDTH-1:0] load_val;

  logic [WIDTH:0]   cur_ext;
  logic [WIDTH:0]   goal_ext;
  logic             going_up;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   step_amt;
  logic [WIDTH:0]   moved;
  logic             reached;

  // Catch an inverted clamp window at elaboration rather than in the field.
  if (MIN_POS > MAX_POS) begin : g_bad_clamp_bounds
    $error("steering_slew_ctrl: MIN_POS must not exceed MAX_POS");
  end

  // Value that a target_valid strobe loads into goal.
`ifdef STEERING_CLAMP_EN
  localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(MIN_POS);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_POS);

  always_comb begin
    load_val = bus.targetDirection;
    if (bus.targetDirection < MIN_VAL) begin
      load_val = MIN_VAL;
    end else if (bus.targetDirection > MAX_VAL) begin
      load_val = MAX_VAL;
    end
  end
`else
  assign load_val = bus.targetDirection;
`endif

  // Update-tick strobe: the counter free-runs and wraps, so a tick that is
  // swallowed by a link stall is simply gone rather than postponed.
  assign tick  = (tick_cnt == CNT_LAST);
  assign stall = ard_valid_q && !bus.ard_ready;

  // Step toward goal in WIDTH+1 bits; the step is limited to the remaining
  // distance, so the result never passes goal and never wraps around zero
  // or past the top of the range.
  assign cur_ext  = {1'b0, current};
  assign goal_ext = {1'b0, goal};
  assign going_up = (goal_ext > cur_ext);
  assign diff     = going_up ? (goal_ext - cur_ext) : (cur_ext - goal_ext);
  assign step_amt = (diff < STEP_VAL) ? diff : STEP_VAL;
  assign moved    = going_up ? (cur_ext + step_amt) : (cur_ext - step_amt);
  assign reached  = (moved == goal_ext);

  // State, goal, current, link flag and tick counter all update here.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= IDLE;
      goal        <= '0;
      current     <= '0;
      ard_valid_q <= 1'b0;
      tick_cnt    <= '0;
    end else begin
      state       <= state_n;
      goal        <= goal_n;
      current     <= current_n;
      ard_valid_q <= ard_valid_n;
      tick_cnt    <= tick ? '0 : (tick_cnt + CNT_W'(1));
    end
  end

  // Next-state logic. Homing beats everything else, and a simultaneous
  // target is dropped. A fresh target replaces the goal in that cycle
  // without also stepping, so the first move toward it lands on a later
  // tick. Movement only happens on an unstalled tick.
  always_comb begin
    state_n   = state;
    goal_n    = goal;
    current_n = current;

    if (bus.reset_Pos) begin
      goal_n  = HOME_VAL;
      state_n = HOME;
    end else if (bus.target_valid && (state != HOME)) begin
      goal_n  = load_val;
      state_n = (load_val != current) ? SLEW : IDLE;
    end else if (state != IDLE) begin
      if (current == goal) begin
        state_n = IDLE;
      end else if (tick && !stall) begin
        current_n = moved[WIDTH-1:0];
        if (reached) begin
          state_n = IDLE;
        end
      end
    end
  end

  // A word stays offered until the link takes it; a new step always
  // re-arms the flag even if the previous word is being accepted.
  always_comb begin
    ard_valid_n = ard_valid_q;
    if (current_n != current) begin
      ard_valid_n = 1'b1;
    end else if (ard_valid_q && bus.ard_ready) begin
      ard_valid_n = 1'b0;
    end
  end

  // Status outputs are pure decodes of registered state.
  assign bus.targetDirection_Ard = current;
  assign bus.ard_valid           = ard_valid_q;
  assign bus.reset_Pos_Ard       = (state == HOME);
  assign bus.busy                = (state != IDLE);
  assign bus.at_target           = (state == IDLE) && (current == goal);

endmodule

// File: doc/steering_slew_ctrl.md
STEERING_SLEW_CTRL -- requirements
Module: steering_slew_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WIDTH, 9, bit width of all direction values.
- STEP, 4, maximum change of commanded direction per update tick.
- DIV, 2, CLOCK_50 cycles per update tick (DIV >= 1).
- HOME_POS, 0, direction driven during homing.
- MIN_POS, 0, lower clamp bound.
- MAX_POS, 511, upper clamp bound.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- CLOCK_50, in, 1, sole clock; all logic on its rising edge.
- reset, in, 1, synchronous active-high reset.
- targetDirection, in, WIDTH, requested steering direction, unsigned.
- target_valid, in, 1, one-cycle strobe that captures targetDirection.
- reset_Pos, in, 1, one-cycle strobe that requests homing.
- ard_ready, in, 1, Arduino link accepts the current word.
- targetDirection_Ard, out, WIDTH, commanded direction sent to the Arduino.
- reset_Pos_Ard, out, 1, high while homing.
- ard_valid, out, 1, targetDirection_Ard holds an untransferred word.
- at_target, out, 1, commanded direction equals goal and state is IDLE.
- busy, out, 1, state is not IDLE.

Function
REQ-003 The block SHALL keep a goal register and a current register, both WIDTH bits; targetDirection_Ard SHALL equal current.
REQ-004 The tick counter SHALL count 0..DIV-1 and wrap; tick SHALL be high in the cycle the count equals DIV-1.
REQ-005 The FSM SHALL have exactly three states: IDLE, SLEW, HOME.
REQ-006 In IDLE or SLEW, target_valid SHALL load goal on the next edge; the state SHALL be SLEW if the new goal differs from current, otherwise IDLE.
REQ-007 In SLEW, on a tick with no stall, current SHALL move toward goal by min(STEP, |goal-current|), computed in unsigned WIDTH+1 bits with no wrap-around; reaching goal SHALL return the state to IDLE.
REQ-008 A stall exists when ard_valid=1 and ard_ready=0; during a stall current SHALL NOT change and the tick SHALL be lost, not deferred.
REQ-009 reset_Pos in any state SHALL load goal with HOME_POS and enter HOME; reset_Pos_Ard SHALL be 1 for every cycle the state is HOME.
REQ-010 HOME SHALL slew exactly as SLEW does and return to IDLE when current equals HOME_POS; target_valid SHALL be ignored while in HOME.
REQ-011 If reset_Pos and target_valid are high in the same cycle, reset_Pos SHALL win and the target SHALL be discarded.
REQ-012 Every change of current SHALL set ard_valid on the same edge; ard_valid SHALL clear on the edge after a cycle with ard_valid=1 and ard_ready=1, unless current changes on that same edge.
REQ-013 at_target SHALL be (state==IDLE) and (current==goal); busy SHALL be (state!=IDLE); both SHALL be registered-state decodes with no input-to-output combinational path.
REQ-014 Latency: a target_valid at cycle N SHALL produce the first change of current on the first unstalled tick at or after cycle N+1.

Reset
REQ-015 When reset=1 at an edge, the following SHALL be loaded: goal=0, current=0, tick count=0, state=IDLE, ard_valid=0. reset_Pos_Ard, busy and at_target then read 0, 0 and 1.
REQ-016 reset SHALL override all other inputs, including a homing or slew in progress.

Configuration
REQ-017 With STEERING_CLAMP_EN defined, targetDirection SHALL be clamped to [MIN_POS, MAX_POS] before loading into goal.
REQ-018 Without STEERING_CLAMP_EN, targetDirection SHALL load into goal unmodified, and MIN_POS and MAX_POS SHALL be unused.

Verification (WIDTH=9, STEP=4, DIV=2, HOME_POS=0, ard_ready=1 unless stated)
REQ-019 Reset, then target_valid with 10 -> current steps 4, 8, 10 on successive ticks; at_target=1 after the step that reaches 10.
REQ-020 current=20, target 5 -> current steps 16, 12, 8, 5; no underflow.
REQ-021 ard_ready=0 after the first step -> current holds 4 and ard_valid stays 1; with ard_ready=1, stepping resumes on the next tick.
REQ-022 current=12, reset_Pos and target_valid(300) in the same cycle -> HOME, reset_Pos_Ard=1, current steps 8, 4, 0; then IDLE and reset_Pos_Ard=0; 300 is discarded.
REQ-023 Reset mid-slew at current=8 -> next cycle current=0, ard_valid=0, busy=0.
REQ-024 With STEERING_CLAMP_EN, MAX_POS=400, target 500 -> goal=400 and slew ends at 400; without the macro, slew ends at 500.
